// File: rtl/ahb_master_arbiter.sv
// Round-robin arbiter sharing one AHB-lite bus controller master port between
// several requesters; ownership covers the full transaction including the drain.
`ifndef AHB_ADDR_WIDTH
`define AHB_ADDR_WIDTH 32
`endif
`ifndef AHB_DATA_WIDTH
`define AHB_DATA_WIDTH 32
`endif

module ahb_master_arbiter #(
  parameter int NUM_MASTERS  = 2,
  parameter int ADDR_W       = `AHB_ADDR_WIDTH,
  parameter int DATA_W       = `AHB_DATA_WIDTH,
  parameter int DRAIN_CYCLES = 3,
  parameter int TIMEOUT      = 255,
  localparam int OW          = (NUM_MASTERS > 2) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_MASTERS-1:0]        m_req,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS-1:0]        m_addr_ctrl,
  input  logic [NUM_MASTERS-1:0]        m_write,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]        m_gnt,
  output logic [NUM_MASTERS-1:0]        m_ready,
  output logic [NUM_MASTERS-1:0]        m_resp,
  output logic [DATA_W-1:0]             m_rdata,
  output logic                          bus_busreq,
  output logic [ADDR_W-1:0]             bus_haddr,
  output logic                          bus_haddr_ctrl,
  output logic                          bus_hwrite,
  output logic [DATA_W-1:0]             bus_hwdata,
  input  logic                          bus_hgrant,
  input  logic                          bus_hready,
  input  logic                          bus_hresp,
  input  logic [DATA_W-1:0]             bus_hdata,
  output logic [OW-1:0]                 owner,
  output logic                          busy,
  output logic                          timeout_err
);

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int DRN_W  = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [WAIT_W-1:0] WAIT_MAX   = WAIT_W'(TIMEOUT);
  localparam logic [DRN_W-1:0]  DRAIN_LAST = DRN_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
  localparam logic [DRN_W-1:0]  DRAIN_MAX  = DRN_W'(DRAIN_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN   = 2'd1,
    ST_BUSY  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [OW-1:0]       owner_q, owner_d;
  logic [OW-1:0]       last_owner_q, last_owner_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [DRN_W-1:0]    drain_cnt_q, drain_cnt_d;
  logic                timeout_err_q, timeout_err_d;
  logic [OW-1:0]       winner;

  logic [ADDR_W-1:0]   addr_arr  [NUM_MASTERS];
  logic [DATA_W-1:0]   wdata_arr [NUM_MASTERS];

  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_unpack
    assign addr_arr[gi]  = m_addr[gi*ADDR_W +: ADDR_W];
    assign wdata_arr[gi] = m_wdata[gi*DATA_W +: DATA_W];
  end

  // First requester strictly after last_owner in circular order.
  always_comb begin
    logic          found;
    logic [OW-1:0] cand;
    // NOTE: every variable written in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    winner = last_owner_q;
    found  = 1'b0;
    cand   = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      cand = OW'((int'(last_owner_q) + k) % NUM_MASTERS);
      if (!found && m_req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_owner_d  = last_owner_q;
    wait_cnt_d    = wait_cnt_q;
    drain_cnt_d   = drain_cnt_q;
    timeout_err_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (|m_req) begin
          owner_d      = winner;
          last_owner_d = winner;
          wait_cnt_d   = '0;
          state_d      = ST_OWN;
        end
      end
      ST_OWN: begin
        if (wait_cnt_q != WAIT_MAX) wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        if (bus_hgrant) begin
          state_d = ST_BUSY;
        end else if (!m_req[owner_q]) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = '0;
        end else if (TIMEOUT != 0 && wait_cnt_q == WAIT_LAST) begin
          // Bus never granted: abort and release the arbiter.
          state_d       = ST_DRAIN;
          drain_cnt_d   = '0;
          timeout_err_d = 1'b1;
        end
      end
      ST_BUSY: begin
        if (!bus_hgrant) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = '0;
        end
      end
      ST_DRAIN: begin
        if (!bus_hready) begin
          drain_cnt_d = '0;
        end else if (drain_cnt_q == DRAIN_LAST) begin
          state_d = ST_IDLE;
        end else if (drain_cnt_q != DRAIN_MAX) begin
          drain_cnt_d = drain_cnt_q + DRN_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Owner's signals stay on the bus through DRAIN; request and grant do not.
  always_comb begin
    bus_busreq     = 1'b0;
    bus_haddr      = '0;
    bus_haddr_ctrl = 1'b0;
    bus_hwrite     = 1'b0;
    bus_hwdata     = '0;
    m_gnt          = '0;
    m_ready        = '0;
    m_resp         = '0;
    if (state_q != ST_IDLE) begin
      bus_haddr        = addr_arr[owner_q];
      bus_haddr_ctrl   = m_addr_ctrl[owner_q];
      bus_hwrite       = m_write[owner_q];
      bus_hwdata       = wdata_arr[owner_q];
      m_ready[owner_q] = bus_hready;
      m_resp[owner_q]  = bus_hresp;
      if (state_q != ST_DRAIN) begin
        bus_busreq     = m_req[owner_q];
        m_gnt[owner_q] = bus_hgrant;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= ST_IDLE;
      owner_q       <= '0;
      last_owner_q  <= OW'(NUM_MASTERS - 1);
      wait_cnt_q    <= '0;
      drain_cnt_q   <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_owner_q  <= last_owner_d;
      wait_cnt_q    <= wait_cnt_d;
      drain_cnt_q   <= drain_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign m_rdata     = bus_hdata;
  assign owner       = owner_q;
  assign busy        = (state_q != ST_IDLE);
  assign timeout_err = timeout_err_q;

endmodule
